// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared types and constants for the register-bank
// write-back front end (regfile_writeback and its wb_slot holding registers).
//   src_e   - identifies which producer slot owns the write port
//   slot_t  - {full, addr, data} view of one holding slot at default widths
//   RST_*   - values the control state takes on reset
package regfile_wb_pkg;

  localparam int AWIDTH_DEF = 3;
  localparam int DWIDTH_DEF = 8;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  typedef struct packed {
    logic                  full;
    logic [AWIDTH_DEF-1:0] addr;
    logic [DWIDTH_DEF-1:0] data;
  } slot_t;

  localparam logic RST_A_OLDER = 1'b1;
  localparam logic RST_WEN     = 1'b0;

endpackage

// File: rtl/wb_slot.sv
// wb_slot: one-entry holding register for a single write-back producer.
// Accepts a result on i_valid && o_ready; results addressed to register 0
// complete the handshake but are not stored. A granted slot drains at the
// next edge and may be refilled on that same edge.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid/o_ready     producer handshake
//   i_addr/i_data       offered result
//   i_grant             this slot owns the write port this cycle
//   o_fill              a storing transfer happens at the coming edge
//   o_full/o_addr/o_data current slot contents
module wb_slot #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_grant,
  output logic              o_fill,
  output logic              o_full,
  output logic [AWIDTH-1:0] o_addr,
  output logic [DWIDTH-1:0] o_data
);

  logic              r_full;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_data;

  // A slot being drained this cycle is free again at the edge.
  assign o_ready = !i_rst && (!r_full || i_grant);
  assign o_fill  = i_valid && o_ready && (i_addr != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full <= 1'b0;
    end else if (o_fill) begin
      r_full <= 1'b1;
    end else if (i_grant) begin
      r_full <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while r_full is set.
  always_ff @(posedge i_clk) begin
    if (o_fill) begin
      r_addr <= i_addr;
      r_data <= i_data;
    end
  end

  assign o_full = r_full;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: serialises register-write results from producer A (ALU)
// and producer B (load/store) onto the bank's single registered write port.
// Each producer has a one-entry slot; the older full slot wins the port, so
// two writes to the same register land in arrival order. Writes to x0 are
// dropped at the slot.
// Ports: clk, rst (sync, active-high); a_/b_ valid, ready, addr, data;
//   wen/waddr/wdata registered write port; idle; fwd_addr -> fwd_hit/fwd_data.
// Build option: define REGFILE_WB_FWD_EN to enable the forwarding lookup;
//   otherwise fwd_hit/fwd_data are tied to 0 and fwd_addr is ignored.
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [DWIDTH-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [DWIDTH-1:0] b_data,
  output logic              wen,
  output logic [AWIDTH-1:0] waddr,
  output logic [DWIDTH-1:0] wdata,
  output logic              idle,
  input  logic [AWIDTH-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DWIDTH-1:0] fwd_data
);

  logic              w_a_fill, w_a_full, w_a_grant;
  logic [AWIDTH-1:0] w_a_addr;
  logic [DWIDTH-1:0] w_a_data;
  logic              w_b_fill, w_b_full, w_b_grant;
  logic [AWIDTH-1:0] w_b_addr;
  logic [DWIDTH-1:0] w_b_data;
  src_e              w_src;

  logic              r_a_older;
  logic              r_wen;
  logic [AWIDTH-1:0] r_waddr;
  logic [DWIDTH-1:0] r_wdata;

  wb_slot #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_slot_a (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_ready),
    .i_addr(a_addr), .i_data(a_data), .i_grant(w_a_grant), .o_fill(w_a_fill),
    .o_full(w_a_full), .o_addr(w_a_addr), .o_data(w_a_data)
  );

  wb_slot #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_slot_b (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_ready),
    .i_addr(b_addr), .i_data(b_data), .i_grant(w_b_grant), .o_fill(w_b_fill),
    .o_full(w_b_full), .o_addr(w_b_addr), .o_data(w_b_data)
  );

  // Grants depend only on registered state, so ready never loops back.
  assign w_a_grant = w_a_full && (!w_b_full || r_a_older);
  assign w_b_grant = w_b_full && (!w_a_full || !r_a_older);
  assign w_src     = w_a_grant ? SRC_A : SRC_B;

  // Age tracking: a slot filling while the other keeps an entry is younger.
  // Simultaneous fills favour A.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_older <= RST_A_OLDER;
    end else if (w_a_fill && w_b_fill) begin
      r_a_older <= 1'b1;
    end else if (w_a_fill) begin
      r_a_older <= !w_b_full || w_b_grant;
    end else if (w_b_fill) begin
      r_a_older <= w_a_full && !w_a_grant;
    end
  end

  // Output stage: write port registered; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen   <= RST_WEN;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_a_grant || w_b_grant;
      if (w_a_grant || w_b_grant) begin
        r_waddr <= (w_src == SRC_A) ? w_a_addr : w_b_addr;
        r_wdata <= (w_src == SRC_A) ? w_a_data : w_b_data;
      end
    end
  end

  assign wen   = r_wen;
  assign waddr = r_waddr;
  assign wdata = r_wdata;
  assign idle  = !w_a_full && !w_b_full && !r_wen;

`ifdef REGFILE_WB_FWD_EN
  logic w_hit_a, w_hit_b, w_hit_o;

  assign w_hit_a = w_a_full && (w_a_addr == fwd_addr);
  assign w_hit_b = w_b_full && (w_b_addr == fwd_addr);
  assign w_hit_o = r_wen && (r_waddr == fwd_addr);

  // Later assignments win: output stage, then older slot, then younger slot.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_addr != '0) begin
      if (w_hit_o) begin
        fwd_hit  = 1'b1;
        fwd_data = r_wdata;
      end
      if (r_a_older) begin
        if (w_hit_a) begin fwd_hit = 1'b1; fwd_data = w_a_data; end
        if (w_hit_b) begin fwd_hit = 1'b1; fwd_data = w_b_data; end
      end else begin
        if (w_hit_b) begin fwd_hit = 1'b1; fwd_data = w_b_data; end
        if (w_hit_a) begin fwd_hit = 1'b1; fwd_data = w_a_data; end
      end
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^fwd_addr;
  assign fwd_hit      = 1'b0;
  assign fwd_data     = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_addr, b_addr, fwd_addr;
  logic [DW-1:0] a_data, b_data;
  logic          wen, idle, fwd_hit;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata, fwd_data;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];

  regfile_writeback #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wen(wen), .waddr(waddr), .wdata(wdata), .idle(idle),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge and retire any write
  // against the scoreboard.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (wen === 1'b1) begin
      chk("waddr_nonzero", 32'(waddr != '0), 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {24'd0, 5'(waddr), wdata[2:0]}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(waddr), 32'(e.addr));
        chk("write_data", 32'(wdata), 32'(e.data));
      end
    end
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; a_data = '0; b_addr = '0; b_data = '0; fwd_addr = '0;

    // Reset state
    tick(); tick();
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    rst = 1'b0;

    // Single A write, latency and idle return
    a_valid = 1'b1; a_addr = 3'd3; a_data = 8'h5A;
    #1 chk("t1_a_ready", 32'(a_ready), 32'd1);
    exp_q.push_back('{addr: 3'd3, data: 8'h5A});
    tick();
    a_valid = 1'b0;
    chk("t1_wen_latency", 32'(wen), 32'd0);
    chk("t1_busy", 32'(idle), 32'd0);
    tick();
    chk("t1_wen", 32'(wen), 32'd1);
    tick();
    chk("t1_idle_after", 32'(idle), 32'd1);
    chk("t1_wen_after", 32'(wen), 32'd0);

    // Write to x0 is dropped
    a_valid = 1'b1; a_addr = 3'd0; a_data = 8'hFF;
    #1 chk("t2_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    chk("t2_idle", 32'(idle), 32'd1);
    tick();
    chk("t2_idle2", 32'(idle), 32'd1);
    chk("t2_wen", 32'(wen), 32'd0);

    // Simultaneous A and B: A first, B ready low while blocked
    a_valid = 1'b1; a_addr = 3'd2; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 3'd5; b_data = 8'h22;
    #1 chk("t3_b_ready0", 32'(b_ready), 32'd1);
    exp_q.push_back('{addr: 3'd2, data: 8'h11});
    exp_q.push_back('{addr: 3'd5, data: 8'h22});
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t3_b_ready_blocked", 32'(b_ready), 32'd0);
    chk("t3_a_ready_granted", 32'(a_ready), 32'd1);
    tick();
    chk("t3_wen1", 32'(wen), 32'd1);
    tick();
    chk("t3_wen2", 32'(wen), 32'd1);
    tick();
    chk("t3_idle", 32'(idle), 32'd1);

    // Same destination ordering: B 4/01 waits behind A, then A refills 4/02
    a_valid = 1'b1; a_addr = 3'd1; a_data = 8'hAA;
    b_valid = 1'b1; b_addr = 3'd4; b_data = 8'h01;
    exp_q.push_back('{addr: 3'd1, data: 8'hAA});
    exp_q.push_back('{addr: 3'd4, data: 8'h01});
    exp_q.push_back('{addr: 3'd4, data: 8'h02});
    tick();
    b_valid = 1'b0;
    a_addr = 3'd4; a_data = 8'h02;
    chk("t4_a_ready_refill", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    chk("t4_a_ready_younger", 32'(a_ready), 32'd0);
    tick(); tick(); tick();
    chk("t4_idle", 32'(idle), 32'd1);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);

    // Forwarding lookup
    a_valid = 1'b1; a_addr = 3'd6; a_data = 8'h33;
    exp_q.push_back('{addr: 3'd6, data: 8'h33});
    tick();
    a_valid = 1'b0;
    fwd_addr = 3'd6;
`ifdef REGFILE_WB_FWD_EN
    #1 chk("t5_fwd_hit", 32'(fwd_hit), 32'd1);
    chk("t5_fwd_data", 32'(fwd_data), 32'h33);
    fwd_addr = 3'd0;
    #1 chk("t5_fwd_x0", 32'(fwd_hit), 32'd0);
    fwd_addr = 3'd6;
    tick();
    chk("t5_fwd_out_hit", 32'(fwd_hit), 32'd1);
    chk("t5_fwd_out_data", 32'(fwd_data), 32'h33);
`else
    #1 chk("t5_fwd_off_hit", 32'(fwd_hit), 32'd0);
    chk("t5_fwd_off_data", 32'(fwd_data), 32'd0);
    tick();
`endif
    fwd_addr = 3'd0;
    tick();

    // Reset with both slots full discards pending writes
    a_valid = 1'b1; a_addr = 3'd1; a_data = 8'h77;
    b_valid = 1'b1; b_addr = 3'd2; b_data = 8'h88;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t6_full", 32'(idle), 32'd0);
    rst = 1'b1;
    #1 chk("t6_rst_a_ready", 32'(a_ready), 32'd0);
    tick();
    chk("t6_rst_wen", 32'(wen), 32'd0);
    chk("t6_rst_idle", 32'(idle), 32'd1);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("t6_no_writes", 32'(wen), 32'd0);
    chk("t6_idle", 32'(idle), 32'd1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
